// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, latched request layout.
package lsu_pkg;

   localparam int unsigned MEM_BYTES_DEFAULT = 64;

   typedef enum logic {
      SZ_BYTE = 1'b0,
      SZ_HALF = 1'b1
   } lsu_size_e;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ACC0 = 2'd1;
   localparam logic [1:0] ACC1 = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   typedef struct packed {
      logic        we;
      logic        size;
      logic        sgn;
      logic [15:0] addr;
      logic [15:0] wdata;
   } lsu_req_t;

   // A halfword is misaligned when it starts on an odd byte.
   function automatic logic is_misaligned(input logic size, input logic addr_lsb);
      return (size == SZ_HALF) && addr_lsb;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Builds the load result from the captured bytes: halfword merge or byte sign/zero extension.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic        size,
   input  logic        sign_ext,
   input  logic [7:0]  lo_byte,
   input  logic [7:0]  hi_byte,
   output logic [15:0] rdata
);

   always_comb begin
      rdata = 16'h0000;
      if (size == SZ_HALF) begin
         rdata = {hi_byte, lo_byte};
      end else if (sign_ext) begin
         rdata = {{8{lo_byte[7]}}, lo_byte};
      end else begin
         rdata = {8'h00, lo_byte};
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// CPU-side initiator for the byte-addressed data memory port; one request in flight at a time,
// misaligned halfwords optionally split into two byte accesses.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES        = MEM_BYTES_DEFAULT,
   parameter bit          SPLIT_MISALIGNED = 1'b1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic        req_size,
   input  logic        req_signed,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [15:0] resp_rdata,
   output logic        resp_err,
   output logic        wmem,
   output logic [15:0] DAddress,
   output logic [15:0] DataIn,
   output logic        memc,
   input  logic [15:0] DataOut
);

   logic [1:0]  state_q, state_d;
   lsu_req_t    req_q;
   logic        err_q;
   logic        split_q;
   logic [7:0]  lo_q, hi_q;

   logic        accept;
   logic        in_misaligned;
   logic        in_err;
   logic [16:0] addr_ext, last_ext, limit;
   logic        wmem_raw;
   logic [15:0] align_rdata;

   assign accept    = req_valid && req_ready;
   assign req_ready = (state_q == IDLE);

   // 17-bit compare so a halfword at 0xFFFF cannot wrap back into range.
   assign addr_ext      = {1'b0, req_addr};
   assign last_ext      = addr_ext + {16'h0000, req_size};
   assign limit         = 17'(MEM_BYTES);
   assign in_misaligned = is_misaligned(req_size, req_addr[0]);
   assign in_err        = (addr_ext >= limit) || (last_ext >= limit)
                          || (in_misaligned && !SPLIT_MISALIGNED);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = in_err ? RESP : ACC0;
            end
         end
         ACC0:    state_d = split_q ? ACC1 : RESP;
         ACC1:    state_d = RESP;
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         req_q   <= '0;
         err_q   <= 1'b0;
         split_q <= 1'b0;
         lo_q    <= 8'h00;
         hi_q    <= 8'h00;
      end else begin
         state_q <= state_d;
         if (accept) begin
            req_q.we    <= req_we;
            req_q.size  <= req_size;
            req_q.sgn   <= req_signed;
            req_q.addr  <= req_addr;
            req_q.wdata <= req_wdata;
            err_q       <= in_err;
            split_q     <= in_misaligned && !in_err;
            lo_q        <= 8'h00;
            hi_q        <= 8'h00;
         end
         if (state_q == ACC0) begin
            lo_q <= DataOut[7:0];
            if (!split_q && (req_q.size == SZ_HALF)) begin
               hi_q <= DataOut[15:8];
            end
         end
         if (state_q == ACC1) begin
            hi_q <= DataOut[7:0];
         end
      end
   end

   always_comb begin
      wmem_raw = 1'b0;
      DAddress = 16'h0000;
      DataIn   = 16'h0000;
      memc     = 1'b0;
      case (state_q)
         ACC0: begin
            DAddress = req_q.addr;
            wmem_raw = req_q.we;
            if (split_q) begin
               memc   = 1'b0;
               DataIn = {8'h00, req_q.wdata[7:0]};
            end else begin
               memc   = req_q.size;
               DataIn = req_q.wdata;
            end
         end
         ACC1: begin
            DAddress = req_q.addr + 16'd1;
            memc     = 1'b0;
            DataIn   = {8'h00, req_q.wdata[15:8]};
            wmem_raw = req_q.we;
         end
         default: ;
      endcase
   end

   // Gating with RESET keeps a reset edge from committing a half-finished store.
   assign wmem = wmem_raw && !RESET;

   lsu_load_align u_align (
      .size     (req_q.size),
      .sign_ext (req_q.sgn),
      .lo_byte  (lo_q),
      .hi_byte  (hi_q),
      .rdata    (align_rdata)
   );

   assign resp_valid = (state_q == RESP);
   assign resp_err   = (state_q == RESP) && err_q;
   assign resp_rdata = ((state_q == RESP) && !err_q && !req_q.we) ? align_rdata : 16'h0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: attached 64-byte memory, behavioural reference model, per-cycle compare.
module tb_load_store_unit;

   localparam int MEMSZ = 64;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        req_valid, req_ready, req_we, req_size, req_signed;
   logic [15:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [15:0] resp_rdata;
   logic        wmem, memc;
   logic [15:0] DAddress, DataIn, DataOut;

   load_store_unit #(
      .MEM_BYTES        (64),
      .SPLIT_MISALIGNED (1'b1)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .wmem       (wmem),
      .DAddress   (DAddress),
      .DataIn     (DataIn),
      .memc       (memc),
      .DataOut    (DataOut)
   );

   always #5 CLK = ~CLK;

   // Attached memory: little-endian, combinational read, write commits at posedge.
   logic [7:0] mem [0:MEMSZ-1];
   logic [7:0] ref_mem [0:MEMSZ-1];
   logic       mem_ready = 1'b0;
   logic [7:0] rb0, rb1;

   always_comb begin
      rb0 = (DAddress < 16'd64) ? mem[DAddress[5:0]] : 8'h00;
      rb1 = (DAddress < 16'd63) ? mem[DAddress[5:0] + 6'd1] : 8'h00;
      DataOut = memc ? {rb1, rb0} : {8'h00, rb0};
   end

   always @(posedge CLK) begin
      if (!mem_ready) begin
         for (int i = 0; i < MEMSZ; i++) mem[i] <= ref_mem[i];
         mem_ready <= 1'b1;
      end else if (wmem && DAddress < 16'd64) begin
         mem[DAddress[5:0]] <= DataIn[7:0];
         if (memc && DAddress < 16'd63) mem[DAddress[5:0] + 6'd1] <= DataIn[15:8];
      end
   end

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] d;
      logic        c;
   } wr_t;

   wr_t         exp_wr [$];
   logic [15:0] exp_rdata;
   logic        exp_err;
   logic        busy;
   int          pulses;
   int          total;
   int          bad;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance to the next falling edge and compare every meaningful output against the model.
   task automatic tick();
      wr_t w;
      @(negedge CLK);
      if (!RESET) begin
         check("req_ready", req_ready, !busy);
         if (wmem) begin
            pulses++;
            if (exp_wr.size() == 0) begin
               check("wmem_unexpected", wmem, 1'b0);
            end else begin
               w = exp_wr.pop_front();
               check("wr_addr", DAddress, w.a);
               check("wr_data", DataIn, w.d);
               check("wr_memc", memc, w.c);
            end
         end
         if (busy) begin
            if (resp_valid) begin
               check("resp_rdata", resp_rdata, exp_rdata);
               check("resp_err", resp_err, exp_err);
            end
         end else begin
            check("resp_valid_idle", resp_valid, 1'b0);
         end
      end
   endtask

   task automatic do_req(input logic we, input logic size, input logic sgn,
                         input logic [15:0] addr, input logic [15:0] wdata, input int hold,
                         output logic [15:0] rd, output logic er, output int lat,
                         output int npulse);
      int          a, last, exp_lat, p0, v;
      logic        mis;
      logic [7:0]  lo, hi;
      a    = addr;
      last = a + size;
      mis  = size && addr[0];
      exp_err   = (a >= MEMSZ) || (last >= MEMSZ);
      exp_rdata = 16'h0000;
      if (exp_err) begin
         exp_lat = 1;
      end else begin
         exp_lat = mis ? 3 : 2;
         if (we) begin
            if (mis) begin
               exp_wr.push_back({addr, {8'h00, wdata[7:0]}, 1'b0});
               exp_wr.push_back({16'(addr + 16'd1), {8'h00, wdata[15:8]}, 1'b0});
            end else begin
               exp_wr.push_back({addr, wdata, size});
            end
            ref_mem[a] = wdata[7:0];
            if (size) ref_mem[a + 1] = wdata[15:8];
         end else begin
            lo = ref_mem[a];
            hi = 8'h00;
            if (size) hi = ref_mem[a + 1];
            if (size) v = hi * 256 + lo;
            else if (sgn && lo >= 128) v = lo - 256;
            else v = lo;
            exp_rdata = v[15:0];
         end
      end
      p0 = pulses;
      req_we     = we;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      req_valid  = 1'b1;
      busy       = 1'b1;
      tick();
      req_valid = 1'b0;
      req_addr  = 16'($urandom);
      req_wdata = 16'($urandom);
      lat = 1;
      while (!resp_valid && lat < 8) begin
         tick();
         lat++;
      end
      check("latency", lat, exp_lat);
      rd = resp_rdata;
      er = resp_err;
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_valid", resp_valid, 1'b1);
         check("hold_rdata", resp_rdata, rd);
         check("hold_err", resp_err, er);
      end
      resp_ready = 1'b1;
      busy       = 1'b0;
      tick();
      resp_ready = 1'b0;
      check("writes_done", exp_wr.size(), 0);
      npulse = pulses - p0;
   endtask

   initial begin
      logic [15:0] rd;
      logic        er;
      int          lat, np;
      logic [15:0] ra;
      int          r;
      total = 0;
      bad = 0;
      pulses = 0;
      busy = 1'b0;
      RESET = 1'b1;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_size = 1'b0;
      req_signed = 1'b0;
      req_addr = 16'h0000;
      req_wdata = 16'h0000;
      resp_ready = 1'b0;
      for (int i = 0; i < MEMSZ; i++) ref_mem[i] = 8'($urandom);

      repeat (3) tick();
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_resp_rdata", resp_rdata, 16'h0000);
      check("rst_resp_err", resp_err, 1'b0);
      check("rst_wmem", wmem, 1'b0);
      check("rst_daddr", DAddress, 16'h0000);
      check("rst_datain", DataIn, 16'h0000);
      check("rst_memc", memc, 1'b0);
      RESET = 1'b0;
      tick();

      do_req(1'b1, 1'b1, 1'b0, 16'h0004, 16'hBEEF, 0, rd, er, lat, np);
      check("beef_store_pulses", np, 1);
      do_req(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000, 0, rd, er, lat, np);
      check("beef_load_data", rd, 16'hBEEF);
      check("beef_load_lat", lat, 2);

      do_req(1'b1, 1'b0, 1'b0, 16'h0009, 16'h0080, 0, rd, er, lat, np);
      do_req(1'b0, 1'b0, 1'b1, 16'h0009, 16'h0000, 0, rd, er, lat, np);
      check("byte_signed", rd, 16'hFF80);
      do_req(1'b0, 1'b0, 1'b0, 16'h0009, 16'h0000, 0, rd, er, lat, np);
      check("byte_unsigned", rd, 16'h0080);

      do_req(1'b1, 1'b1, 1'b0, 16'h0007, 16'h1234, 0, rd, er, lat, np);
      check("split_store_pulses", np, 2);
      check("split_mem7", mem[7], 8'h34);
      check("split_mem8", mem[8], 8'h12);
      do_req(1'b0, 1'b1, 1'b0, 16'h0007, 16'h0000, 0, rd, er, lat, np);
      check("split_load_data", rd, 16'h1234);
      check("split_load_lat", lat, 3);

      do_req(1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 0, rd, er, lat, np);
      check("oob_byte_err", er, 1'b1);
      check("oob_byte_rdata", rd, 16'h0000);
      check("oob_byte_lat", lat, 1);
      do_req(1'b1, 1'b1, 1'b0, 16'h003F, 16'hA5A5, 0, rd, er, lat, np);
      check("oob_half_err", er, 1'b1);
      check("oob_half_pulses", np, 0);

      do_req(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000, 5, rd, er, lat, np);
      check("hold_load_data", rd, 16'hBEEF);

      // Reset lands on the edge closing ACC0 of a store: nothing may be written.
      req_we = 1'b1;
      req_size = 1'b0;
      req_signed = 1'b0;
      req_addr = 16'h0009;
      req_wdata = 16'h0055;
      req_valid = 1'b1;
      @(posedge CLK);
      #1;
      req_valid = 1'b0;
      RESET = 1'b1;
      #1;
      check("reset_gates_wmem", wmem, 1'b0);
      tick();
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      tick();
      check("post_reset_ready", req_ready, 1'b1);
      check("post_reset_resp", resp_valid, 1'b0);
      check("post_reset_mem9", mem[9], 8'h80);
      do_req(1'b0, 1'b0, 1'b0, 16'h0009, 16'h0000, 0, rd, er, lat, np);
      check("post_reset_load", rd, 16'h0080);

      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 9);
         ra = (r == 0) ? 16'($urandom) : 16'($urandom_range(0, 66));
         do_req(1'($urandom), 1'($urandom), 1'($urandom), ra, 16'($urandom),
                $urandom_range(0, 3), rd, er, lat, np);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
